// File: rtl/unified_mem_scheduler.sv
// Shares one single-ported synchronous memory between instruction fetch and load/store data.
// Latency: a read granted in cycle T returns in cycle T+1; one access per cycle, no bubbles.
// Backpressure: if_ready/d_ready are per-cycle grants; requesters hold req/addr until granted.
// Ports: clk/rst (sync, active-high); if_* fetch port (req/addr/flush in, ready/rvalid/rdata out);
//        d_* load/store port (req/we/addr/wdata/be in, ready/rvalid/rdata out);
//        mem_* memory side (en/we/addr/wdata/be out, rdata in, valid one cycle after a read).
module unified_mem_scheduler #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_ready,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ready,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Owner of the read issued in the previous cycle.
  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_INST = 2'd1,
    PEND_DATA = 2'd2
  } pend_t;

  pend_t      pend, pend_next;
  logic [3:0] starve_cnt, starve_next;
  logic       grant_d, grant_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= PEND_NONE;
      starve_cnt <= 4'd0;
    end else begin
      pend       <= pend_next;
      starve_cnt <= starve_next;
    end
  end

  always_comb begin
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_be      = '0;
    pend_next   = PEND_NONE;
    starve_next = starve_cnt;
    if_ready    = 1'b0;
    d_ready     = 1'b0;
    if_rvalid   = 1'b0;
    if_rdata    = '0;
    d_rvalid    = 1'b0;
    d_rdata     = '0;

    if (!rst) begin
      // Data wins unless fetch has been passed over STARVE_LIMIT times in a row;
      // a flushed fetch is not a competitor at all.
      grant_d  = d_req && (!if_req || if_flush || (starve_cnt < LIMIT));
      grant_i  = if_req && !if_flush && !grant_d;
      d_ready  = grant_d;
      if_ready = grant_i;

      if (grant_d) begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_be    = d_be;
        if (!d_we) pend_next = PEND_DATA;
      end else if (grant_i) begin
        mem_en    = 1'b1;
        mem_addr  = if_addr;
        pend_next = PEND_INST;
      end

      // Only a live, passed-over fetch ages the counter; a flushed one holds it.
      if (grant_i || !if_req) begin
        starve_next = 4'd0;
      end else if (grant_d && !if_flush) begin
        starve_next = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
      end

      // Return stage for last cycle's read; a redirect discards a fetch return.
      case (pend)
        PEND_INST: begin
          if_rvalid = !if_flush;
          if_rdata  = mem_rdata;
        end
        PEND_DATA: begin
          d_rvalid = 1'b1;
          d_rdata  = mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_scheduler.sv
module tb_unified_mem_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_ready, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ready, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       nm;
    logic        ir, dr, en, we, iv, dv;
    logic [31:0] addr, wd;
    logic [3:0]  be;
  } exp_t;

  typedef struct {
    logic        inst;
    logic [31:0] data;
  } rsp_t;

  exp_t cyc_q[$];
  rsp_t rsp_q[$];

  unified_mem_scheduler #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: every read returns its address + 0x100 one cycle later.
  always @(posedge clk) mem_rdata <= mem_addr + 32'h100;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: per-cycle control/bus check, plus response scoreboard popped on each rvalid.
  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      exp_t e;
      e = cyc_q.pop_front();
      chk({e.nm, ".if_ready"},  {31'd0, if_ready},  {31'd0, e.ir});
      chk({e.nm, ".d_ready"},   {31'd0, d_ready},   {31'd0, e.dr});
      chk({e.nm, ".mem_en"},    {31'd0, mem_en},    {31'd0, e.en});
      chk({e.nm, ".mem_we"},    {31'd0, mem_we},    {31'd0, e.we});
      chk({e.nm, ".mem_addr"},  mem_addr,           e.addr);
      chk({e.nm, ".mem_wdata"}, mem_wdata,          e.wd);
      chk({e.nm, ".mem_be"},    {28'd0, mem_be},    {28'd0, e.be});
      chk({e.nm, ".if_rvalid"}, {31'd0, if_rvalid}, {31'd0, e.iv});
      chk({e.nm, ".d_rvalid"},  {31'd0, d_rvalid},  {31'd0, e.dv});
      if (rst) begin
        chk({e.nm, ".if_rdata_rst"}, if_rdata, 32'd0);
        chk({e.nm, ".d_rdata_rst"},  d_rdata,  32'd0);
      end
    end
    if (if_rvalid) begin
      if (rsp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_if_rvalid actual=%h required=none", if_rdata);
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        chk("rsp.owner_inst", {31'd0, 1'b1}, {31'd0, r.inst});
        chk("rsp.if_rdata", if_rdata, r.data);
      end
    end
    if (d_rvalid) begin
      if (rsp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_d_rvalid actual=%h required=none", d_rdata);
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        chk("rsp.owner_data", {31'd0, 1'b0}, {31'd0, r.inst});
        chk("rsp.d_rdata", d_rdata, r.data);
      end
    end
  end

  // One cycle: drive inputs just after the rising edge and queue what the monitor must see.
  task automatic cyc(input string nm, input logic r, input logic ir, input logic [31:0] ia,
                     input logic fl, input logic dr, input logic dw, input logic [31:0] da,
                     input logic [31:0] wd, input logic [3:0] be,
                     input logic e_ir, input logic e_dr, input logic e_iv, input logic e_dv,
                     input logic [31:0] e_rd);
    exp_t e;
    rsp_t s;
    @(posedge clk);
    #1;
    rst = r; if_req = ir; if_addr = ia; if_flush = fl;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = wd; d_be = be;
    e.nm   = nm;
    e.ir   = e_ir;
    e.dr   = e_dr;
    e.en   = e_ir | e_dr;
    e.we   = e_dr & dw;
    e.addr = e_dr ? da : (e_ir ? ia : 32'd0);
    e.wd   = e_dr ? wd : 32'd0;
    e.be   = e_dr ? be : 4'd0;
    e.iv   = e_iv;
    e.dv   = e_dv;
    cyc_q.push_back(e);
    if (e_iv || e_dv) begin
      s.inst = e_iv;
      s.data = e_rd;
      rsp_q.push_back(s);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;

    //  name      rst ir ia        fl dr dw da        wd            be     eir edr eiv edv rdata
    cyc("rst0",    1, 0, 32'h0,     0, 0, 0, 32'h0,   32'h0,        4'h0,  0, 0, 0, 0, 32'h0);
    cyc("rst1",    1, 1, 32'h44,    0, 1, 0, 32'h48,  32'h0,        4'h0,  0, 0, 0, 0, 32'h0);

    // Fetch-only stream
    cyc("f0",      0, 1, 32'h0,     0, 0, 0, 32'h0,   32'h0,        4'h0,  1, 0, 0, 0, 32'h0);
    cyc("f1",      0, 1, 32'h4,     0, 0, 0, 32'h0,   32'h0,        4'h0,  1, 0, 1, 0, 32'h100);
    cyc("f2",      0, 1, 32'h8,     0, 0, 0, 32'h0,   32'h0,        4'h0,  1, 0, 1, 0, 32'h104);
    cyc("f3",      0, 0, 32'h0,     0, 0, 0, 32'h0,   32'h0,        4'h0,  0, 0, 1, 0, 32'h108);

    // Conflict: data first, fetch granted back-to-back while data returns
    cyc("c0",      0, 1, 32'h20,    0, 1, 0, 32'h400, 32'h0,        4'h0,  0, 1, 0, 0, 32'h0);
    cyc("c1",      0, 1, 32'h20,    0, 0, 0, 32'h0,   32'h0,        4'h0,  1, 0, 0, 1, 32'h500);
    cyc("c2",      0, 0, 32'h0,     0, 0, 0, 32'h0,   32'h0,        4'h0,  0, 0, 1, 0, 32'h120);

    // Starvation: both held; expected grants D,D,D,D,I,D,D,D,D,I
    for (int k = 0; k < 10; k++) begin
      logic is_i, prev_i;
      is_i   = (k == 4) || (k == 9);
      prev_i = (k == 5);
      cyc($sformatf("starve%0d", k), 0, 1, 32'h200, 0, 1, 0, 32'h300, 32'h0, 4'h0,
          is_i, !is_i, prev_i, (k != 0) && !prev_i, prev_i ? 32'h300 : 32'h400);
    end
    cyc("starve_end", 0, 0, 32'h0,  0, 0, 0, 32'h0,   32'h0,        4'h0,  0, 0, 1, 0, 32'h300);

    // Store: passes through to memory, no response
    cyc("st0",     0, 0, 32'h0,     0, 1, 1, 32'h80,  32'hDEADBEEF, 4'h3,  0, 1, 0, 0, 32'h0);
    cyc("st1",     0, 0, 32'h0,     0, 0, 0, 32'h0,   32'h0,        4'h0,  0, 0, 0, 0, 32'h0);

    // Flush kills the in-flight fetch return and blocks the new fetch for one cycle
    cyc("fl0",     0, 1, 32'h40,    0, 0, 0, 32'h0,   32'h0,        4'h0,  1, 0, 0, 0, 32'h0);
    cyc("fl1",     0, 1, 32'h100,   1, 0, 0, 32'h0,   32'h0,        4'h0,  0, 0, 0, 0, 32'h0);
    cyc("fl2",     0, 1, 32'h100,   0, 0, 0, 32'h0,   32'h0,        4'h0,  1, 0, 0, 0, 32'h0);
    cyc("fl3",     0, 0, 32'h0,     0, 0, 0, 32'h0,   32'h0,        4'h0,  0, 0, 1, 0, 32'h200);
    // Flush leaves data traffic alone
    cyc("fl4",     0, 1, 32'h60,    1, 1, 0, 32'h90,  32'h0,        4'h0,  0, 1, 0, 0, 32'h0);
    cyc("fl5",     0, 0, 32'h0,     0, 0, 0, 32'h0,   32'h0,        4'h0,  0, 0, 0, 1, 32'h190);

    // Reset mid-read: pending load dropped, no response after release
    cyc("rm0",     0, 0, 32'h0,     0, 1, 0, 32'h404, 32'h0,        4'h0,  0, 1, 0, 0, 32'h0);
    cyc("rm1",     1, 0, 32'h0,     0, 1, 0, 32'h408, 32'h0,        4'h0,  0, 0, 0, 0, 32'h0);
    cyc("rm2",     0, 0, 32'h0,     0, 0, 0, 32'h0,   32'h0,        4'h0,  0, 0, 0, 0, 32'h0);

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("cyc_q_drained", cyc_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unified_mem_scheduler.md
Name: unified_mem_scheduler

Overview:
- Cycle-level scheduler sharing one single-ported synchronous memory (1-cycle read latency) between the instruction-fetch port and the load/store data port of the RISC-V core.
- Data accesses normally take priority over fetches. A bounded-starvation counter guarantees fetch progress.
- The scheduler tracks which requester owns the in-flight read and steers the returned word to that requester. It also supports a fetch-flush for branch redirects.

Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits.
- STARVE_LIMIT, 4, maximum consecutive data grants while a fetch is waiting; range 1..15.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- if_req  input  1  fetch request.
- if_addr  input  ADDR_W  fetch address.
- if_flush  input  1  kill fetch traffic this cycle (redirect).
- if_ready  output  1  fetch accepted this cycle.
- if_rvalid  output  1  fetch data valid.
- if_rdata  output  DATA_W  instruction word.
- d_req  input  1  data request.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_be  input  DATA_W/8  store byte enables.
- d_ready  output  1  data request accepted this cycle.
- d_rvalid  output  1  load data valid.
- d_rdata  output  DATA_W  load data.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_be  output  DATA_W/8  memory byte enables.
- mem_rdata  input  DATA_W  memory read data, valid one cycle after a read strobe.

Behaviour:
- State consists of two registers:
  - pend ∈ {NONE, INST, DATA}: the owner of the read issued in the previous cycle.
  - starve_cnt, 4 bits.
- Reset (rst high at a clock edge): pend=NONE, starve_cnt=0.
- Outputs while rst is high: no grants, mem_en=0, all response valids 0, all output buses 0.
- Arbitration is combinational each cycle, with no bubble between back-to-back grants:
  - grant_d = d_req & (!if_req | if_flush | starve_cnt < STARVE_LIMIT)
  - grant_i = if_req & !if_flush & !grant_d
  - d_ready = grant_d; if_ready = grant_i.
- Memory drive:
  - On grant_d: mem_en=1, mem_we=d_we, mem_addr=d_addr, mem_wdata=d_wdata, mem_be=d_be.
  - On grant_i: mem_en=1, mem_we=0, mem_addr=if_addr, mem_wdata=0, mem_be=0.
  - Otherwise: mem_en=0 and all memory buses 0.
- pend next value:
  - DATA if grant_d & !d_we.
  - INST if grant_i.
  - Else NONE. Stores produce no response.
- Response stage, in the cycle after issue:
  - pend=INST: if_rvalid = !if_flush, if_rdata = mem_rdata.
  - pend=DATA: d_rvalid=1, d_rdata = mem_rdata.
  - The non-selected rdata output is driven 0. Both valids are 0 when pend=NONE.
- Latency: a read accepted in cycle T returns in cycle T+1. Issue and return overlap, so throughput is 1 access/cycle.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when grant_d & if_req & !if_flush.
  - Clears to 0 when grant_i, or when if_req=0.
  - Otherwise holds.
  - When starve_cnt == STARVE_LIMIT and both ports request, the fetch wins exactly once; the counter then clears.
- if_flush:
  - Blocks fetch grants in that cycle.
  - Suppresses an INST response due in that cycle (the data is discarded; pend still returns to NONE or the newly issued owner).
  - Has no effect on data traffic.
- Simultaneous events:
  - A response delivery and a new grant in the same cycle are independent.
  - Data response delivery never blocks a fetch grant.
- Reset mid-operation: a pending response is dropped; no rvalid is asserted in the cycle after reset is released.
- Requesters must hold req/addr stable until their ready is seen. The scheduler keeps no request buffer.

Test Plan:
- Fetch only:
  - Stimulus: if_req=1 at addresses 0x0, 0x4, 0x8 on consecutive cycles; memory returns addr+0x100.
  - Required: if_ready=1 every cycle; if_rvalid on cycles 1-3 with if_rdata 0x100, 0x104, 0x108.
- Conflict:
  - Stimulus: if_req=1 @0x20 and d_req=1 load @0x400 in the same cycle.
  - Required: d_ready=1, if_ready=0, mem_addr=0x400. Next cycle: d_rvalid=1 and if_ready=1 with mem_addr=0x20.
- Starvation (STARVE_LIMIT=4):
  - Stimulus: d_req and if_req held high continuously.
  - Required: grant pattern D,D,D,D,I,D,D,D,D,I; starve_cnt reaches 4 before each fetch grant.
- Store:
  - Stimulus: d_we=1, d_addr=0x80, d_wdata=0xDEADBEEF, d_be=4'b0011.
  - Required: mem_en=1, mem_we=1, mem_be=0011 on the same cycle; no d_rvalid on the next cycle.
- Flush:
  - Stimulus: fetch @0x40 accepted in cycle T; if_flush=1 in T+1 with if_req=1 @0x100.
  - Required: if_rvalid=0 and if_ready=0 in T+1. Fetch @0x100 is accepted in T+2 once flush drops.
- Reset mid-read:
  - Stimulus: load accepted in T; rst=1 in T+1.
  - Required: d_rvalid=0 in T+1 and T+2; all mem outputs 0 during reset.
